// File: rtl/rfphoenix_ififo_arbiter_pkg.sv
// Shared constants and types for the per-thread instruction FIFO issue arbiter.
//   NTHREADS_DEF   : default number of hardware threads / FIFOs (power of 2)
//   FLUSH_HOLD_DEF : default cycles a flushed thread's read stays suppressed
//   TID_W / tid_t  : thread-id width and type for the default configuration
package rfphoenix_ififo_arbiter_pkg;

  localparam int NTHREADS_DEF   = 4;
  localparam int FLUSH_HOLD_DEF = 8;
  localparam int TID_W          = $clog2(NTHREADS_DEF);

  typedef logic [TID_W-1:0] tid_t;

endpackage

// File: rtl/rfphoenix_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per thread
//   last  : index granted most recently; the search starts at last+1
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted request (0 when none)
//   any   : at least one request present
module rfphoenix_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Visit last+1 .. last+N in order; the W-bit add wraps naturally because N
  // is a power of two, and the final candidate (i == N) is `last` itself, so
  // a thread only wins twice in a row when nobody else is requesting.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last + W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rfphoenix_ififo_arbiter.sv
// Issue arbiter for the per-thread instruction FIFO bank (std read mode,
// read latency 1). Picks one eligible thread per cycle round-robin, drives
// its FIFO read enable, presents the tid of the word on the FIFO dout to the
// register-read stage, and sequences per-thread flushes.
//   clk, rst       : clock; asynchronous active-low reset (0 = reset)
//   fifo_empty     : per-FIFO empty flag
//   fifo_v         : per-FIFO data_valid
//   thread_stall   : thread ineligible this cycle
//   flush          : single-cycle flush request per thread
//   fifo_rd        : one-hot (or zero) read enable to the FIFOs
//   fifo_flush     : registered one-cycle reset pulse to each FIFO
//   issue_v        : dout of FIFO[issue_tid] holds a valid instruction
//   issue_tid      : thread owning the presented instruction
//   issue_rdy      : downstream ready
//   err            : sticky, fifo_v[issue_tid] seen low while issue_v high
//
// Handshake: issue_v/issue_tid form a valid/ready source. A transfer happens
// on a rising edge where issue_v & issue_rdy. While issue_v is high and
// issue_rdy is low, issue_v and issue_tid hold and no FIFO is read, so the
// FIFO dout holds too. issue_v never drops without a transfer except on a
// flush of the presented thread or reset.
module rfphoenix_ififo_arbiter
  import rfphoenix_ififo_arbiter_pkg::*;
#(
  parameter int NTHREADS   = NTHREADS_DEF,
  parameter int FLUSH_HOLD = FLUSH_HOLD_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NTHREADS-1:0]           fifo_empty,
  input  logic [NTHREADS-1:0]           fifo_v,
  input  logic [NTHREADS-1:0]           thread_stall,
  input  logic [NTHREADS-1:0]           flush,
  output logic [NTHREADS-1:0]           fifo_rd,
  output logic [NTHREADS-1:0]           fifo_flush,
  output logic                          issue_v,
  output logic [$clog2(NTHREADS)-1:0]   issue_tid,
  input  logic                          issue_rdy,
  output logic                          err
);

  localparam int TW = $clog2(NTHREADS);
  localparam int HW = $clog2(FLUSH_HOLD + 1);

  logic [TW-1:0]                rr_ptr_q, rr_ptr_d;
  logic                         issue_v_q, issue_v_d;
  logic [TW-1:0]                issue_tid_q, issue_tid_d;
  logic [NTHREADS-1:0]          fifo_flush_q, fifo_flush_d;
  logic [NTHREADS-1:0][HW-1:0]  hold_q, hold_d;
  logic                         err_q, err_d;

  logic [NTHREADS-1:0] eligible;
  logic [NTHREADS-1:0] pick_grant;
  logic [TW-1:0]       pick_idx;
  logic                pick_any;
  logic                advance;
  logic                rd_fire;

  always_comb begin
    eligible = '0;
    for (int t = 0; t < NTHREADS; t++) begin
      eligible[t] = !fifo_empty[t] && !thread_stall[t] && !flush[t] && (hold_q[t] == '0);
    end
  end

  rfphoenix_rr_pick #(.N(NTHREADS), .W(TW)) u_pick (
    .req   (eligible),
    .last  (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The output slot can take a new word when empty or draining this cycle.
  // Reads are also held off while reset is asserted so no FIFO word is popped
  // into a pipeline that is being cleared.
  assign advance = !issue_v_q || issue_rdy;
  assign rd_fire = rst && advance && pick_any;
  assign fifo_rd = rd_fire ? pick_grant : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    issue_v_d   = issue_v_q;
    issue_tid_d = issue_tid_q;

    if (rd_fire) begin
      rr_ptr_d    = pick_idx;
      issue_v_d   = 1'b1;
      issue_tid_d = pick_idx;
    end else if (advance || flush[issue_tid_q]) begin
      // Slot drained with nothing behind it, or the presented word belongs
      // to a thread being flushed and must be discarded.
      issue_v_d = 1'b0;
    end

    fifo_flush_d = flush;

    hold_d = hold_q;
    for (int t = 0; t < NTHREADS; t++) begin
      if (flush[t]) begin
        hold_d[t] = HW'(FLUSH_HOLD);
      end else if (hold_q[t] != '0) begin
        hold_d[t] = hold_q[t] - HW'(1);
      end
    end

    err_d = err_q || (issue_v_q && !fifo_v[issue_tid_q]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q     <= TW'(NTHREADS - 1);
      issue_v_q    <= 1'b0;
      issue_tid_q  <= '0;
      fifo_flush_q <= '0;
      hold_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      issue_v_q    <= issue_v_d;
      issue_tid_q  <= issue_tid_d;
      fifo_flush_q <= fifo_flush_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
    end
  end

  assign fifo_flush = fifo_flush_q;
  assign issue_v    = issue_v_q;
  assign issue_tid  = issue_tid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rfphoenix_ififo_arbiter.sv
module tb_rfphoenix_ififo_arbiter;
  import rfphoenix_ififo_arbiter_pkg::*;

  localparam int NT = NTHREADS_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NT-1:0] fifo_empty, fifo_v, thread_stall, flush;
  logic [NT-1:0] fifo_rd, fifo_flush;
  logic          issue_v, issue_rdy, err;
  tid_t          issue_tid;

  rfphoenix_ififo_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_v       (fifo_v),
    .thread_stall (thread_stall),
    .flush        (flush),
    .fifo_rd      (fifo_rd),
    .fifo_flush   (fifo_flush),
    .issue_v      (issue_v),
    .issue_tid    (issue_tid),
    .issue_rdy    (issue_rdy),
    .err          (err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are already driven (just after a rising edge); compare on the
  // falling edge, then move to just after the next rising edge.
  task automatic check(input string name, input logic [NT-1:0] e_rd, input logic [NT-1:0] e_fl,
                       input logic e_v, input tid_t e_tid, input logic e_err);
    @(negedge clk);
    cmp({name, ".fifo_rd"},    32'(fifo_rd),    32'(e_rd));
    cmp({name, ".fifo_flush"}, 32'(fifo_flush), 32'(e_fl));
    cmp({name, ".issue_v"},    32'(issue_v),    32'(e_v));
    cmp({name, ".issue_tid"},  32'(issue_tid),  32'(e_tid));
    cmp({name, ".err"},        32'(err),        32'(e_err));
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NT-1:0] e, input logic [NT-1:0] s,
                       input logic [NT-1:0] f, input logic r);
    fifo_empty   = e;
    thread_stall = s;
    flush        = f;
    issue_rdy    = r;
  endtask

  typedef struct packed {
    logic [NT-1:0] empty;
    logic [NT-1:0] stall;
    logic [NT-1:0] flsh;
    logic          rdy;
    logic [NT-1:0] e_rd;
    logic          e_v;
    tid_t          e_tid;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    // empty        stall    flush    rdy   exp rd   v     tid
    // all empty: nothing ever read
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    // all non-empty, full rate rotation, tid one cycle behind rd
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    // only T2 non-empty, downstream not ready for 3 cycles
    vecs[9]  = '{4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0};
    vecs[10] = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[11] = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[12] = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[13] = '{4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[14] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    // T1 stalled: 3,0,2,3,0 then stall dropped -> T1 at its turn
    vecs[15] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd2};
    vecs[16] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[17] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd0};
    vecs[18] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[19] = '{4'b0000, 4'b0010, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[20] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[21] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst    = 1'b0;
    fifo_v = '1;
    drive(4'b1111, 4'b0000, 4'b0000, 1'b1);

    check("reset0", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    check("reset1", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].empty, vecs[i].stall, vecs[i].flsh, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].e_rd, 4'b0000, vecs[i].e_v, vecs[i].e_tid, 1'b0);
    end

    // Flush T3 while its word is presented and not accepted.
    drive(4'b0111, 4'b0000, 4'b0000, 1'b0);
    check("fl_rd3", 4'b1000, 4'b0000, 1'b0, 2'd1, 1'b0);
    check("fl_pend", 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0);
    drive(4'b0111, 4'b0000, 4'b1000, 1'b0);
    check("fl_req", 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0);
    drive(4'b0111, 4'b0000, 4'b0000, 1'b1);
    check("fl_pulse", 4'b0000, 4'b1000, 1'b0, 2'd3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("fl_hold%0d", i), 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);
    end
    check("fl_resume", 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b0);

    // fifo_v low under a presented word -> sticky err.
    drive(4'b1111, 4'b0000, 4'b0000, 1'b1);
    fifo_v = 4'b0111;
    check("err_cause", 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0);
    fifo_v = '1;
    check("err_set", 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1);
    check("err_stick0", 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1);
    check("err_stick1", 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1);

    // Reset in the middle of traffic clears everything at once.
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("pre_rst", 4'b0001, 4'b0000, 1'b0, 2'd3, 1'b1);
    rst = 1'b0;
    check("mid_rst", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    check("post_rst0", 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
    check("post_rst1", 4'b0010, 4'b0000, 1'b1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
